// File: rtl/ysyx_23060180_lsu.sv
// Load/store unit for the multicycle core: one request at a time, aligned and
// lane-replicated stores, extended loads, error/timeout reporting.
module ysyx_23060180_lsu #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rstn_in,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [2:0]        req_func3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [4:0]        req_rd,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic [4:0]        rsp_rd,
  output logic [1:0]        rsp_err,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_err
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] TO_MAX  = CW'(TIMEOUT);

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_ILL = 2'b01;
  localparam logic [1:0] ERR_BUS = 2'b10;
  localparam logic [1:0] ERR_TO  = 2'b11;

  typedef enum logic [1:0] {IDLE, CHECK, WAIT, RESP} state_t;

  state_t state, state_nxt;

  logic              wr_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   rdata_q;
  logic [1:0]        err_q;
  logic [CW-1:0]     cnt_q;

  logic              illegal, misal, bad, timeout_hit;
  logic [2:0]        low_mask;
  logic [OW-1:0]     off;
  logic [XLEN-1:0]   raw, keep, load_ext, wrep;
  logic [6:0]        nbits;
  logic              sign;
  logic [NB-1:0]     lane_mask, strb;

  // Access decode from the registered request
  always_comb begin
    illegal = (f3_q == 3'b111) || (wr_q && f3_q[2]) ||
              ((XLEN == 32) && ((f3_q == 3'b011) || (f3_q == 3'b110)));
    case (f3_q[1:0])
      2'd0:    low_mask = 3'b000;
      2'd1:    low_mask = 3'b001;
      2'd2:    low_mask = 3'b011;
      default: low_mask = 3'b111;
    endcase
    misal       = |(addr_q[2:0] & low_mask);
    bad         = illegal || misal;
    off         = addr_q[OW-1:0];
    timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);
  end

  // Load lane select and extension
  always_comb begin
    raw   = mem_rdata >> {off, 3'b000};
    nbits = 7'd8 << f3_q[1:0];
    keep  = ~({XLEN{1'b1}} << nbits);
    case (f3_q[1:0])
      2'd0:    sign = raw[7];
      2'd1:    sign = raw[15];
      2'd2:    sign = raw[31];
      default: sign = 1'b0;
    endcase
    if (f3_q[2])
      sign = 1'b0;
    load_ext = (raw & keep) | (sign ? ~keep : '0);
  end

  // Store lane replication and byte strobes
  always_comb begin
    case (f3_q[1:0])
      2'd0:    wrep = {NB{wdata_q[7:0]}};
      2'd1:    wrep = {(NB/2){wdata_q[15:0]}};
      2'd2:    wrep = {(NB/4){wdata_q[31:0]}};
      default: wrep = wdata_q;
    endcase
    lane_mask = NB'((9'd1 << (4'd1 << f3_q[1:0])) - 9'd1);
    strb      = lane_mask << off;
  end

  always_ff @(posedge clk or negedge rstn_in) begin
    if (!rstn_in)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = CHECK;
      CHECK:   state_nxt = bad ? RESP : WAIT;
      WAIT:    if (mem_ack || timeout_hit) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    rsp_rdata = '0;
    rsp_rd    = '0;
    rsp_err   = '0;
    mem_rd    = '0;
    mem_wr    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    case (state)
      IDLE: req_ready = rstn_in;
      WAIT: begin
        mem_rd    = !wr_q;
        mem_wr    = wr_q;
        mem_addr  = {addr_q[ADDR_W-1:OW], {OW{1'b0}}};
        mem_wdata = wrep;
        mem_wstrb = wr_q ? strb : '0;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_q;
        rsp_rd    = wr_q ? 5'd0 : rd_q;
        rsp_err   = err_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn_in) begin
    if (!rstn_in) begin
      wr_q    <= '0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      rdata_q <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          wr_q    <= req_wr;
          f3_q    <= req_func3;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          rd_q    <= req_rd;
          rdata_q <= '0;
          err_q   <= ERR_OK;
        end
        CHECK: begin
          cnt_q <= '0;
          if (bad) begin
            err_q   <= ERR_ILL;
            rdata_q <= '0;
          end
        end
        WAIT: begin
          if (mem_ack) begin
            err_q   <= mem_err ? ERR_BUS : ERR_OK;
            rdata_q <= (mem_err || wr_q) ? '0 : load_ext;
          end else begin
            if (timeout_hit)
              err_q <= ERR_TO;
            if (cnt_q != TO_MAX)
              cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060180_lsu.sv
// Bench for ysyx_23060180_lsu: a 32-bit (TIMEOUT=4) and a 64-bit instance share
// request/memory stimulus; `sel` picks which one is driven and observed.
module tb_ysyx_23060180_lsu;

  logic        clk = 1'b0;
  logic        rstn_in = 1'b0;
  bit          sel = 1'b0;
  logic        req_valid = 1'b0, req_wr = 1'b0, rsp_ready = 1'b0;
  logic [2:0]  req_func3 = '0;
  logic [31:0] req_addr = '0;
  logic [63:0] req_wdata = '0, mem_rdata = '0;
  logic [4:0]  req_rd = '0;
  logic        mem_ack = 1'b0, mem_err = 1'b0;

  logic a_req_valid, b_req_valid, a_mem_ack, b_mem_ack;
  logic a_req_ready, a_rsp_valid, a_mem_rd, a_mem_wr;
  logic b_req_ready, b_rsp_valid, b_mem_rd, b_mem_wr;
  logic [31:0] a_rsp_rdata, a_mem_addr, a_mem_wdata, b_mem_addr;
  logic [63:0] b_rsp_rdata, b_mem_wdata;
  logic [4:0]  a_rsp_rd, b_rsp_rd;
  logic [1:0]  a_rsp_err, b_rsp_err;
  logic [3:0]  a_mem_wstrb;
  logic [7:0]  b_mem_wstrb;

  logic        o_req_ready, o_rsp_valid, o_mem_rd, o_mem_wr;
  logic [63:0] o_rsp_rdata, o_mem_wdata;
  logic [31:0] o_mem_addr;
  logic [4:0]  o_rsp_rd;
  logic [1:0]  o_rsp_err;
  logic [7:0]  o_mem_wstrb;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  assign a_req_valid = req_valid & ~sel;
  assign b_req_valid = req_valid & sel;
  assign a_mem_ack   = mem_ack & ~sel;
  assign b_mem_ack   = mem_ack & sel;

  assign o_req_ready = sel ? b_req_ready : a_req_ready;
  assign o_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
  assign o_rsp_rdata = sel ? b_rsp_rdata : {32'b0, a_rsp_rdata};
  assign o_rsp_rd    = sel ? b_rsp_rd    : a_rsp_rd;
  assign o_rsp_err   = sel ? b_rsp_err   : a_rsp_err;
  assign o_mem_rd    = sel ? b_mem_rd    : a_mem_rd;
  assign o_mem_wr    = sel ? b_mem_wr    : a_mem_wr;
  assign o_mem_addr  = sel ? b_mem_addr  : a_mem_addr;
  assign o_mem_wdata = sel ? b_mem_wdata : {32'b0, a_mem_wdata};
  assign o_mem_wstrb = sel ? b_mem_wstrb : {4'b0, a_mem_wstrb};

  ysyx_23060180_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) u_lsu32 (
    .clk(clk), .rstn_in(rstn_in),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_wr(req_wr),
    .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
    .req_rd(req_rd), .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(a_rsp_rdata), .rsp_rd(a_rsp_rd), .rsp_err(a_rsp_err),
    .mem_rd(a_mem_rd), .mem_wr(a_mem_wr), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_wstrb(a_mem_wstrb), .mem_ack(a_mem_ack),
    .mem_rdata(mem_rdata[31:0]), .mem_err(mem_err)
  );

  ysyx_23060180_lsu #(.XLEN(64), .ADDR_W(32), .TIMEOUT(8)) u_lsu64 (
    .clk(clk), .rstn_in(rstn_in),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wr(req_wr),
    .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd), .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_rd(b_rsp_rd), .rsp_err(b_rsp_err),
    .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_wstrb(b_mem_wstrb), .mem_ack(b_mem_ack),
    .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  typedef struct {
    bit        s;
    bit        wr;
    bit [2:0]  f3;
    bit [31:0] addr;
    bit [63:0] wd;
    bit [63:0] md;
    bit        merr;
    bit [1:0]  err;
    bit [63:0] rdata;
    bit [7:0]  strb;
    bit [63:0] wrep;
    bit [31:0] maddr;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(bit s, bit wr, bit [2:0] f3, bit [31:0] addr, bit [63:0] wd,
                              bit [63:0] md, bit merr, bit [1:0] err, bit [63:0] rdata,
                              bit [7:0] strb, bit [63:0] wrep, bit [31:0] maddr);
    vec_t v;
    v.s = s; v.wr = wr; v.f3 = f3; v.addr = addr; v.wd = wd; v.md = md; v.merr = merr;
    v.err = err; v.rdata = rdata; v.strb = strb; v.wrep = wrep; v.maddr = maddr;
    return v;
  endfunction

  // Reference: byte-level view of the access rules
  function automatic vec_t model(bit s, bit wr, bit [2:0] f3, bit [31:0] addr,
                                 bit [63:0] wd, bit [63:0] md, bit merr);
    vec_t v;
    int unsigned nb, size, off;
    bit ill;
    v = mk(s, wr, f3, addr, wd, md, merr, 2'd0, '0, '0, '0, '0);
    nb   = s ? 8 : 4;
    size = 1 << f3[1:0];
    ill  = (f3 == 3'd7) || (wr && f3[2]) || (!s && (f3 == 3'd3 || f3 == 3'd6));
    if (ill || (addr % size) != 0) begin
      v.err = 2'd1;
      return v;
    end
    off     = addr % nb;
    v.maddr = addr - off;
    for (int unsigned i = 0; i < nb; i++)
      v.wrep[8*i +: 8] = wd[8*(i % size) +: 8];
    if (wr)
      for (int unsigned i = 0; i < size; i++)
        v.strb[off + i] = 1'b1;
    if (merr) begin
      v.err = 2'd2;
    end else if (!wr) begin
      for (int unsigned i = 0; i < size; i++)
        v.rdata[8*i +: 8] = md[8*(off + i) +: 8];
      if (!f3[2] && size < 8 && v.rdata[8*size - 1])
        for (int unsigned j = size; j < nb; j++)
          v.rdata[8*j +: 8] = 8'hFF;
    end
    return v;
  endfunction

  task automatic run_txn(input string nm, input vec_t v, input logic [4:0] rd, input int dly);
    @(negedge clk);
    sel = v.s; req_valid = 1'b1; req_wr = v.wr; req_func3 = v.f3;
    req_addr = v.addr; req_wdata = v.wd; req_rd = rd;
    #1 chk({nm, ".req_ready"}, o_req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    chk({nm, ".check_idle"}, {o_mem_rd, o_mem_wr}, 0);
    if (v.err == 2'd1) begin
      @(negedge clk);
      chk({nm, ".no_mem"}, {o_mem_rd, o_mem_wr}, 0);
    end else begin
      @(negedge clk);
      chk({nm, ".mem_rd"}, o_mem_rd, !v.wr);
      chk({nm, ".mem_wr"}, o_mem_wr, v.wr);
      chk({nm, ".mem_addr"}, o_mem_addr, v.maddr);
      chk({nm, ".mem_wstrb"}, o_mem_wstrb, v.strb);
      if (v.wr) chk({nm, ".mem_wdata"}, o_mem_wdata, v.wrep);
      for (int i = 0; i < dly; i++) begin
        chk({nm, ".hold"}, {o_mem_rd, o_mem_wr, o_rsp_valid}, {!v.wr, v.wr, 1'b0});
        @(negedge clk);
      end
      mem_ack = 1'b1; mem_err = v.merr; mem_rdata = v.md;
      @(negedge clk);
      mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = '0;
      chk({nm, ".mem_drop"}, {o_mem_rd, o_mem_wr}, 0);
    end
    chk({nm, ".rsp_valid"}, o_rsp_valid, 1);
    chk({nm, ".rsp_err"}, o_rsp_err, v.err);
    chk({nm, ".rsp_rdata"}, o_rsp_rdata, v.rdata);
    chk({nm, ".rsp_rd"}, o_rsp_rd, v.wr ? 5'd0 : rd);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({nm, ".rsp_done"}, {o_rsp_valid, o_req_ready}, 2'b01);
  endtask

  vec_t vecs[20];

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test, expected finish within time limit");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   n;

    vecs[0]  = mk(0, 1, 3'd0, 32'h80000003, 64'hA5, 0, 0, 0, 0, 8'h08, 64'hA5A5A5A5, 32'h80000000);
    vecs[1]  = mk(0, 0, 3'd0, 32'h80000002, 0, 64'h12F03456, 0, 0, 64'hFFFFFFF0, 0, 0, 32'h80000000);
    vecs[2]  = mk(0, 0, 3'd4, 32'h80000002, 0, 64'h12F03456, 0, 0, 64'h000000F0, 0, 0, 32'h80000000);
    vecs[3]  = mk(0, 0, 3'd1, 32'h80000002, 0, 64'h12F03456, 0, 0, 64'h000012F0, 0, 0, 32'h80000000);
    vecs[4]  = mk(0, 0, 3'd2, 32'h80000002, 0, 0, 0, 1, 0, 0, 0, 0);
    vecs[5]  = mk(0, 1, 3'd4, 32'h80000000, 64'h55, 0, 0, 1, 0, 0, 0, 0);
    vecs[6]  = mk(0, 1, 3'd1, 32'h80000002, 64'hBEEF1234, 0, 0, 0, 0, 8'h0C, 64'h12341234, 32'h80000000);
    vecs[7]  = mk(0, 1, 3'd2, 32'h80000004, 64'hDEADBEEF, 0, 0, 0, 0, 8'h0F, 64'hDEADBEEF, 32'h80000004);
    vecs[8]  = mk(0, 0, 3'd3, 32'h80000000, 0, 0, 0, 1, 0, 0, 0, 0);
    vecs[9]  = mk(0, 0, 3'd1, 32'h80000001, 0, 0, 0, 1, 0, 0, 0, 0);
    vecs[10] = mk(0, 0, 3'd2, 32'h80000000, 0, 64'h89ABCDEF, 1, 2, 0, 0, 0, 32'h80000000);
    vecs[11] = mk(1, 0, 3'd3, 32'h80000008, 0, 64'h0123456789ABCDEF, 0, 0, 64'h0123456789ABCDEF, 0, 0, 32'h80000008);
    vecs[12] = mk(1, 0, 3'd2, 32'h80000004, 0, 64'h8000000100000000, 0, 0, 64'hFFFFFFFF80000001, 0, 0, 32'h80000000);
    vecs[13] = mk(1, 0, 3'd6, 32'h80000004, 0, 64'h8000000100000000, 0, 0, 64'h0000000080000001, 0, 0, 32'h80000000);
    vecs[14] = mk(1, 1, 3'd3, 32'h80000010, 64'h1122334455667788, 0, 0, 0, 0, 8'hFF, 64'h1122334455667788, 32'h80000010);
    vecs[15] = mk(1, 1, 3'd0, 32'h80000005, 64'h7E, 0, 0, 0, 0, 8'h20, 64'h7E7E7E7E7E7E7E7E, 32'h80000000);
    vecs[16] = mk(1, 0, 3'd0, 32'h80000007, 0, 64'h8000000000000000, 0, 0, 64'hFFFFFFFFFFFFFF80, 0, 0, 32'h80000000);
    vecs[17] = mk(1, 0, 3'd7, 32'h80000000, 0, 0, 0, 1, 0, 0, 0, 0);
    vecs[18] = mk(1, 1, 3'd2, 32'h80000004, 64'hCAFEF00D, 0, 1, 2, 0, 8'hF0, 64'hCAFEF00DCAFEF00D, 32'h80000000);
    vecs[19] = mk(0, 0, 3'd5, 32'h80000002, 0, 64'h80010000, 0, 0, 64'h00008001, 0, 0, 32'h80000000);

    // Reset state on both instances
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = bit'(s);
      #1;
      chk("reset.req_ready", o_req_ready, 0);
      chk("reset.outputs", {o_rsp_valid, o_mem_rd, o_mem_wr, o_rsp_err}, 0);
    end
    @(negedge clk);
    rstn_in = 1'b1;
    sel = 1'b0;
    #1 chk("reset.release_ready", o_req_ready, 1);

    for (int i = 0; i < 20; i++)
      run_txn($sformatf("vec%0d", i), vecs[i], 5'(i + 1), i % 3);

    // Timeout on the 32-bit instance (TIMEOUT=4), then a late ack is ignored
    @(negedge clk);
    sel = 1'b0; req_valid = 1'b1; req_wr = 1'b0; req_func3 = 3'd2;
    req_addr = 32'h80000000; req_rd = 5'd3;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && !o_rsp_valid; i++) begin
      @(negedge clk);
      if (o_mem_rd) n++;
    end
    chk("timeout.rd_cycles", n, 4);
    chk("timeout.rsp_valid", o_rsp_valid, 1);
    chk("timeout.rsp_err", o_rsp_err, 2'b11);
    @(negedge clk);
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 64'h12345678;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = '0;
    chk("timeout.late_ack", {o_rsp_valid, o_rsp_err, o_mem_rd}, {1'b1, 2'b11, 1'b0});
    chk("timeout.late_rdata", o_rsp_rdata, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    run_txn("timeout.next_lw", model(0, 0, 3'd2, 32'h80000008, 0, 64'h76543210, 0), 5'd4, 1);

    // Response backpressure with a request waiting
    @(negedge clk);
    sel = 1'b0; req_valid = 1'b1; req_wr = 1'b0; req_func3 = 3'd4;
    req_addr = 32'h80000001; req_rd = 5'd7;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("bp.mem_rd", o_mem_rd, 1);
    mem_ack = 1'b1; mem_rdata = 64'h0000AB00;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 5; i++) begin
      chk("bp.rsp", {o_rsp_valid, o_rsp_err, o_rsp_rd, o_req_ready}, {1'b1, 2'b00, 5'd7, 1'b0});
      chk("bp.rdata", o_rsp_rdata, 64'hAB);
      if (i == 1) begin
        req_valid = 1'b1; req_func3 = 3'd2; req_addr = 32'h80000001; req_rd = 5'd9;
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp.after_hs", {o_rsp_valid, o_req_ready}, 2'b01);
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp.accepted", o_req_ready, 0);
    @(negedge clk);
    chk("bp.second_rsp", {o_rsp_valid, o_rsp_err, o_rsp_rd}, {1'b1, 2'b01, 5'd9});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp.second_done", o_rsp_valid, 0);

    // Reset pulse while the 64-bit instance waits on memory
    @(negedge clk);
    sel = 1'b1; req_valid = 1'b1; req_wr = 1'b0; req_func3 = 3'd2;
    req_addr = 32'h80000004; req_rd = 5'd5;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst.mem_rd_before", o_mem_rd, 1);
    #2 rstn_in = 1'b0;
    #1;
    chk("rst.mem_rd_async", o_mem_rd, 0);
    chk("rst.req_ready_low", o_req_ready, 0);
    @(negedge clk);
    rstn_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst.idle", {o_rsp_valid, o_mem_rd, o_req_ready}, 3'b001);
    end
    run_txn("rst.after", model(1, 0, 3'd3, 32'h80000018, 0, 64'hFEDCBA9876543210, 0), 5'd6, 0);

    // Randomized traffic against the byte-level reference
    for (int i = 0; i < 100; i++) begin
      bit        s, wr, merr;
      bit [2:0]  f3;
      bit [31:0] addr;
      bit [63:0] wd, md;
      s    = 1'($urandom_range(0, 1));
      wr   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = 32'h80000000 | 32'($urandom_range(0, 63));
      wd   = {$urandom, $urandom};
      md   = {$urandom, $urandom};
      if (!s) md[63:32] = '0;
      merr = ($urandom_range(0, 7) == 0);
      v = model(s, wr, f3, addr, wd, md, merr);
      run_txn($sformatf("rnd%0d", i), v, 5'($urandom_range(1, 31)), int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
